// File: rtl/x25519.sv
// x25519: RFC 7748 X25519 scalar multiplication using a constant-time Montgomery ladder and Fermat inversion.
// All field arithmetic goes through one shared mod-p add/sub/mul unit with 128-bit multiplier digits.
module x25519 (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] scalar,
   input  logic [255:0] point_in,
   output logic [255:0] point_out,
   output logic         valid
);
   typedef enum logic [2:0] {IDLE, LADDER, INVERT, FINAL, DONE} state_t;
   localparam logic [255:0] P = {1'b0, {250{1'b1}}, 5'b01101};
   localparam logic [255:0] E = {1'b0, {250{1'b1}}, 5'b01011};
   localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2;
   localparam logic [3:0] X1 = 4'd0, X2 = 4'd1, Z2 = 4'd2, X3 = 4'd3, Z3 = 4'd4, T0 = 4'd5,
                          T1 = 4'd6, T2 = 4'd7, T3 = 4'd8, K = 4'd9, R = 4'd10;
   // One ladder step as {op, dst, src_a, src_b}; slot 0 is the cswap cycle and never executes.
   localparam logic [13:0] PROG [19] = '{
      14'd0,
      {OP_ADD, T0, X2, Z2},
      {OP_SUB, T1, X2, Z2},
      {OP_ADD, T2, X3, Z3},
      {OP_SUB, T3, X3, Z3},
      {OP_MUL, T3, T3, T0},
      {OP_MUL, T2, T2, T1},
      {OP_MUL, T0, T0, T0},
      {OP_MUL, T1, T1, T1},
      {OP_ADD, X3, T3, T2},
      {OP_SUB, Z3, T3, T2},
      {OP_MUL, X3, X3, X3},
      {OP_MUL, Z3, Z3, Z3},
      {OP_MUL, Z3, Z3, X1},
      {OP_MUL, X2, T0, T1},
      {OP_SUB, T1, T0, T1},
      {OP_MUL, T2, T1, K},
      {OP_ADD, T2, T2, T0},
      {OP_MUL, Z2, T1, T2}
   };

   function automatic logic [255:0] bswap(input logic [255:0] x);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
      return r;
   endfunction

   function automatic logic [255:0] mod_add(input logic [255:0] x, input logic [255:0] y);
      logic [256:0] s;
      s = 257'(x) + 257'(y);
      return s >= 257'(P) ? 256'(s - 257'(P)) : s[255:0];
   endfunction

   function automatic logic [255:0] mod_sub(input logic [255:0] x, input logic [255:0] y);
      return x >= y ? x - y : x + (P - y);
   endfunction

   // 2^256 = 38 and 2^255 = 19 mod p; two folds leave a value below 2p.
   function automatic logic [255:0] mod_red(input logic [511:0] x);
      logic [262:0] t;
      logic [255:0] u;
      t = 263'(x[255:0]) + 263'(x[511:256]) * 263'(38);
      u = 256'(t[254:0]) + 256'(t[262:255]) * 256'(19);
      return u >= P ? u - P : u;
   endfunction

   state_t state_q, state_d;
   logic [10:0][255:0] rf_q, rf_d;
   logic [255:0] k_q, k_d, point_out_q, point_out_d, a, b, res, ks, ud;
   logic [383:0] acc_q, acc_d;
   logic [511:0] prod;
   logic [8:0] bit_q, bit_d;
   logic [4:0] pc_q, pc_d;
   logic [13:0] inst;
   logic [1:0] op;
   logic [3:0] dst;
   logic cnt_q, cnt_d, swap_q, swap_d, valid_q, valid_d, exec, fin, kt, sw, nxt;

   assign inst = state_q == INVERT ? {OP_MUL, R, R, pc_q[0] ? Z2 : R}
               : state_q == FINAL ? {OP_MUL, X2, X2, R} : PROG[pc_q];
   assign op = inst[13:12];
   assign dst = inst[11:8];
   assign a = rf_q[inst[7:4]];
   assign b = rf_q[inst[3:0]];
   assign prod = {acc_q & {384{cnt_q}}, 128'd0} + 512'(a) * 512'(cnt_q ? b[127:0] : b[255:128]);
   assign fin = op != OP_MUL || cnt_q;
   assign res = op == OP_ADD ? mod_add(a, b) : op == OP_SUB ? mod_sub(a, b) : mod_red(prod);
   assign exec = (state_q == LADDER && pc_q != 5'd0) || state_q == INVERT || state_q == FINAL;
   assign kt = !bit_q[8] && k_q[bit_q[7:0]];
   assign sw = swap_q ^ kt;
   assign nxt = pc_q[0] || !E[bit_q[7:0]];
   assign ks = bswap(scalar);
   assign ud = bswap(point_in) & {1'b0, {255{1'b1}}};
   assign point_out = point_out_q;
   assign valid = valid_q;

   always_comb begin
      state_d = state_q;
      rf_d = rf_q;
      k_d = k_q;
      bit_d = bit_q;
      pc_d = pc_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      swap_d = swap_q;
      point_out_d = point_out_q;
      valid_d = valid_q;
      if (exec) begin
         acc_d = prod[383:0];
         cnt_d = !fin;
         if (fin) rf_d[dst] = res;
      end
      case (state_q)
         IDLE: begin
            k_d = (ks & ~256'd7 & {1'b0, {255{1'b1}}}) | (256'd1 << 254);
            rf_d = '0;
            rf_d[X1] = ud >= P ? ud - P : ud;
            rf_d[X3] = ud >= P ? ud - P : ud;
            rf_d[X2] = 256'd1;
            rf_d[Z3] = 256'd1;
            rf_d[R] = 256'd1;
            rf_d[K] = 256'd121665;
            bit_d = 9'd254;
            pc_d = 5'd0;
            swap_d = 1'b0;
            state_d = LADDER;
         end
         LADDER: begin
            if (pc_q == 5'd0) begin
               // bit_q wraps past zero into the trailing swap-only step
               rf_d[X2] = sw ? rf_q[X3] : rf_q[X2];
               rf_d[X3] = sw ? rf_q[X2] : rf_q[X3];
               rf_d[Z2] = sw ? rf_q[Z3] : rf_q[Z2];
               rf_d[Z3] = sw ? rf_q[Z2] : rf_q[Z3];
               swap_d = kt;
               pc_d = bit_q[8] ? 5'd0 : 5'd1;
               bit_d = bit_q[8] ? 9'd254 : bit_q;
               state_d = bit_q[8] ? INVERT : LADDER;
            end else if (fin) begin
               pc_d = pc_q == 5'd18 ? 5'd0 : pc_q + 5'd1;
               bit_d = pc_q == 5'd18 ? bit_q - 9'd1 : bit_q;
            end
         end
         INVERT: begin
            if (fin) begin
               pc_d = nxt ? 5'd0 : 5'd1;
               bit_d = nxt ? bit_q - 9'd1 : bit_q;
               state_d = nxt && bit_q == 9'd0 ? FINAL : INVERT;
            end
         end
         FINAL: begin
            if (fin) begin
               point_out_d = bswap(res);
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rf_q <= '0;
         k_q <= '0;
         bit_q <= '0;
         pc_q <= '0;
         cnt_q <= 1'b0;
         acc_q <= '0;
         swap_q <= 1'b0;
         point_out_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rf_q <= rf_d;
         k_q <= k_d;
         bit_q <= bit_d;
         pc_q <= pc_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         swap_q <= swap_d;
         point_out_q <= point_out_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: tb/tb_x25519.sv
// tb_x25519: vector table from RFC 7748 plus a random case checked against a big-integer X25519 model,
// with abort/restart, asynchronous reset, input-isolation, hold and fixed-latency checks.
module tb_x25519;
   localparam logic [255:0] P = {1'b0, {250{1'b1}}, 5'b01101};

   typedef struct {
      logic [255:0] sc;
      logic [255:0] pt;
      logic [255:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [255:0] scalar = '0;
   logic [255:0] point_in = '0;
   logic [255:0] point_out;
   logic valid;
   int n_chk = 0;
   int n_pass = 0;
   int lat0 = -1;
   vec_t tbl [4];

   x25519 dut (
      .clk(clk),
      .rst(rst),
      .scalar(scalar),
      .point_in(point_in),
      .point_out(point_out),
      .valid(valid)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] le(input logic [255:0] s);
      logic [255:0] r;
      for (int k = 0; k < 32; k++) r[8*k +: 8] = s[255-8*k -: 8];
      return r;
   endfunction

   function automatic logic [255:0] fmul(input logic [255:0] x, input logic [255:0] y);
      logic [511:0] t;
      t = 512'(x) * 512'(y);
      return 256'(t % 512'(P));
   endfunction

   function automatic logic [255:0] fadd(input logic [255:0] x, input logic [255:0] y);
      return 256'((257'(x) + 257'(y)) % 257'(P));
   endfunction

   function automatic logic [255:0] fsub(input logic [255:0] x, input logic [255:0] y);
      return 256'((257'(x) + 257'(P) - 257'(y)) % 257'(P));
   endfunction

   function automatic logic [255:0] fpow(input logic [255:0] base, input logic [255:0] e);
      logic [255:0] r;
      r = 256'd1;
      for (int i = 0; i < 256; i++) begin
         if (e[i]) r = fmul(r, base);
         base = fmul(base, base);
      end
      return r;
   endfunction

   function automatic logic [255:0] ref_x25519(input logic [255:0] sc, input logic [255:0] pt);
      logic [255:0] k, x1, x2, z2, x3, z3, ta, aa, tb, bb, te, tc, td, da, cb, tmp;
      logic swap;
      k = le(sc);
      k[2:0] = 3'b000;
      k[255] = 1'b0;
      k[254] = 1'b1;
      x1 = le(pt);
      x1[255] = 1'b0;
      x1 = x1 % P;
      x2 = 256'd1;
      z2 = 256'd0;
      x3 = x1;
      z3 = 256'd1;
      swap = 1'b0;
      for (int t = 254; t >= 0; t--) begin
         swap = swap ^ k[t];
         if (swap) begin
            tmp = x2; x2 = x3; x3 = tmp;
            tmp = z2; z2 = z3; z3 = tmp;
         end
         swap = k[t];
         ta = fadd(x2, z2);
         aa = fmul(ta, ta);
         tb = fsub(x2, z2);
         bb = fmul(tb, tb);
         te = fsub(aa, bb);
         tc = fadd(x3, z3);
         td = fsub(x3, z3);
         da = fmul(td, ta);
         cb = fmul(tc, tb);
         x3 = fmul(fadd(da, cb), fadd(da, cb));
         z3 = fmul(x1, fmul(fsub(da, cb), fsub(da, cb)));
         x2 = fmul(aa, bb);
         z2 = fmul(te, fadd(aa, fmul(256'd121665, te)));
      end
      if (swap) begin
         x2 = x3;
         z2 = z3;
      end
      return le(fmul(x2, fpow(z2, P - 256'd2)));
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string what, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", what, got, exp);
   endtask

   task automatic pulse(input logic [255:0] sc, input logic [255:0] pt);
      @(negedge clk);
      rst = 1'b1;
      scalar = sc;
      point_in = pt;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_done(input int id, input logic [255:0] exp, input bit scramble);
      int cyc;
      logic leak, held;
      logic [255:0] first;
      cyc = 0;
      leak = 1'b0;
      held = 1'b1;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         if (scramble) begin
            scalar = rnd256();
            point_in = rnd256();
         end
         if (!valid && point_out !== '0) leak = 1'b1;
      end while (!valid && cyc < 90000);
      chk($sformatf("run%0d valid", id), 256'(valid), 256'd1);
      chk($sformatf("run%0d early_out", id), 256'(leak), 256'd0);
      chk($sformatf("run%0d result", id), point_out, exp);
      if (lat0 < 0) lat0 = cyc;
      else chk($sformatf("run%0d latency", id), 256'(cyc), 256'(lat0));
      first = point_out;
      repeat (16) begin
         @(posedge clk);
         #1;
         if (valid !== 1'b1 || point_out !== first) held = 1'b0;
      end
      chk($sformatf("run%0d hold", id), 256'(held), 256'd1);
   endtask

   initial begin
      logic [255:0] sc, pt, e;
      tbl[0] = '{256'h77076d0a7318a57d3c16c17251b26645df4c2f87ebc0992ab177fba51db92c2a,
                 {8'h09, 248'h0},
                 256'h8520f0098930a754748b7ddcb43ef75a0dbf3a0d26381af4eba4a98eaa9b4e6a};
      tbl[1] = '{256'h5dab087e624a8a4b79e17f8b83800ee66f3bb1292618b6fd1c2f8b27ff88e0eb,
                 {8'h09, 248'h0},
                 256'hde9edb7d7b7dc1b4d35b61c2ece435373f8343c85b78674dadfc7e146f882b4f};
      tbl[2] = '{256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4,
                 256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c,
                 256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552};
      tbl[3] = '{tbl[0].sc, {8'h09, 240'h0, 8'h80}, tbl[0].exp};

      repeat (3) @(negedge clk);
      chk("reset valid", 256'(valid), 256'd0);
      chk("reset out", point_out, 256'd0);

      for (int i = 0; i < 4; i++) begin
         pulse(tbl[i].sc, tbl[i].pt);
         wait_done(i, tbl[i].exp, 1'b1);
      end

      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async valid", 256'(valid), 256'd0);
      chk("async out", point_out, 256'd0);

      pulse(tbl[0].sc, tbl[0].pt);
      repeat (1000) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort valid", 256'(valid), 256'd0);
      chk("abort out", point_out, 256'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_done(10, tbl[0].exp, 1'b0);

      sc = rnd256();
      pt = rnd256();
      e = ref_x25519(sc, pt);
      pulse(sc, pt);
      wait_done(20, e, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/x25519.md
X25519 -- requirements
Module: x25519

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 256 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset; while high, all state is cleared and no computation runs.
REQ-004 scalar  input  256  X25519 private scalar, RFC 7748 32-byte string; byte k occupies bits [255-8k : 248-8k].
REQ-005 point_in  input  256  input u-coordinate, RFC 7748 32-byte little-endian string, same byte mapping as scalar.
REQ-006 point_out  output  256  result u-coordinate, same byte mapping as the inputs.
REQ-007 valid  output  1  high when point_out holds the finished result.

Function
REQ-008 The block SHALL compute point_out = X25519(scalar, point_in) over Curve25519 with p = 2^255-19 and a24 = 121665, per RFC 7748.
REQ-009 No start strobe: the computation SHALL begin on the first rising clk edge after rst deasserts.
REQ-010 scalar and point_in SHALL be captured on that first edge; later input changes SHALL NOT affect the running operation.
REQ-011 Scalar decode (clamping): clear bits 0-2 of byte 0, clear bit 7 of byte 31, set bit 6 of byte 31.
REQ-012 u decode: clear bit 7 of byte 31 (the input's top bit); non-canonical values in [p, 2^255) SHALL be accepted and reduced mod p.
REQ-013 The block SHALL run a constant-time Montgomery ladder over scalar bits 254 down to 0, with a conditional swap per bit and a final swap, using projective (X:Z) coordinates.
REQ-014 Z SHALL be inverted by Fermat exponentiation (Z^(p-2)); the affine result x2*Z^(p-2) SHALL be fully reduced into [0, p) before output.
REQ-015 If the final Z is 0, point_out SHALL be 0 (natural result of Fermat inversion).
REQ-016 Arithmetic SHALL use one shared sequential field unit (mod-p add, sub, multiply) driven by a control FSM; the multiplier SHALL be digit-serial (at least 16 multiplier bits per cycle).
REQ-017 FSM states: IDLE/LOAD (capture and decode), LADDER (per-bit step sequence), INVERT (exponentiation chain), FINAL (multiply, reduce, byte-encode), DONE.
REQ-018 The total latency from rst deassertion to valid rising SHALL be a fixed number of cycles, independent of data, and no greater than 90,000 cycles.
REQ-019 point_out SHALL be written in the same cycle valid rises, and both SHALL hold steady until the next rst assertion.
REQ-020 The block SHALL NOT start a new operation after DONE; a new operation requires an rst pulse.
REQ-021 point_out SHALL read 0 at all times before valid rises; intermediate values SHALL NOT appear on it.

Reset
REQ-022 While rst is high: valid = 0, point_out = 0, FSM = IDLE, working registers cleared; asynchronous effect, no clock edge needed.
REQ-023 Asserting rst mid-operation SHALL abort the operation immediately; after deassertion a fresh operation SHALL start with the current inputs.
REQ-024 A one-cycle rst pulse SHALL be sufficient for a full reset.

Verification
REQ-025 scalar=77076d0a7318a57d3c16c17251b26645df4c2f87ebc0992ab177fba51db92c2a, point_in=09 followed by 31 zero bytes -> valid rises, point_out=8520f0098930a754748b7ddcb43ef75a0dbf3a0d26381af4eba4a98eaa9b4e6a.
REQ-026 scalar=5dab087e624a8a4b79e17f8b83800ee66f3bb1292618b6fd1c2f8b27ff88e0eb, point_in=09 followed by 31 zero bytes -> point_out=de9edb7d7b7dc1b4d35b61c2ece435373f8343c85b78674dadfc7e146f882b4f.
REQ-027 scalar from REQ-025, point_in = result of REQ-026 -> point_out=4a5d9d5ba4ce2de1728e3bf480350f25e07e21c947d19e3376f09b3c1e161742.
REQ-028 scalar=a546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4, point_in=e6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c -> point_out=c3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552.
REQ-029 Same inputs as REQ-025, but point_in byte 31 = 0x80 (top bit set) -> same point_out as REQ-025 (top bit masked).
REQ-030 REQ-025 inputs; assert rst 1,000 cycles after start, then release -> valid and point_out are 0 at once; the rerun gives the REQ-025 result after the same fixed latency, which is at most 90,000 cycles.
